// File: rtl/code_mem_loader_pkg.sv
// rtl/code_mem_loader_pkg.sv - shared constants and state encodings for the code memory loader
//
// Purpose: bus width constants, instruction address step, default code memory
// depth and the loader FSM state type shared by the loader and its byte packer.
package code_mem_loader_pkg;

  localparam int BUS_W         = 32;
  localparam int BUS_MSB       = BUS_W - 1;
  // Byte distance between consecutive instruction words; equals the fetch PC step.
  localparam int PC_INC        = 4;
  localparam int MAX_WORDS_DEF = 1024;

  typedef enum logic [2:0] {
    ST_WAIT_MEM = 3'd0,
    ST_LEN      = 3'd1,
    ST_DATA     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_CHECK    = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } loaderState_t;

endpackage

// File: rtl/code_mem_loader_byte_packer.sv
// rtl/code_mem_loader_byte_packer.sv - 4-byte big-endian shift-in register with word-ready pulse
//
// Purpose: collects bytes MSB first into a 32-bit word. Only the first three
// bytes are stored; the fourth is combined combinationally so the completed
// word is visible in the same cycle its last byte is presented.
// Ports:
//   i_Clk, i_Rst   clock, synchronous active-high reset
//   i_Clear        synchronous clear of shift register and byte counter
//   i_Valid        byte strobe (already qualified by the caller)
//   i_Byte         incoming byte
//   o_Word         {stored bytes, i_Byte}; meaningful when o_WordReady is high
//   o_WordReady    high while the 4th byte of a word is being presented
module code_mem_loader_byte_packer (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Clear,
  input  logic        i_Valid,
  input  logic [7:0]  i_Byte,
  output logic [31:0] o_Word,
  output logic        o_WordReady
);

  logic [23:0] shiftReg;
  logic [1:0]  byteCnt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      shiftReg <= '0;
      byteCnt  <= '0;
    end else if (i_Valid) begin
      shiftReg <= {shiftReg[15:0], i_Byte};
      // 2-bit counter wraps 3->0, so the next word starts cleanly.
      byteCnt  <= byteCnt + 2'd1;
    end
  end

  assign o_WordReady = i_Valid && (byteCnt == 2'd3);
  assign o_Word      = {shiftReg, i_Byte};

endmodule

// File: rtl/code_mem_loader.sv
// rtl/code_mem_loader.sv - boot-time loader writing a serial byte image into code memory
//
// Purpose: receives <4-byte word count N><N big-endian words><1 XOR checksum byte>,
// writes each word to consecutive word addresses and releases the CPU once the
// checksum matches. The CPU stays in reset with fetch disabled until then.
// Ports:
//   i_Clk, i_Rst      clock, synchronous active-high reset
//   i_RxValid/i_RxData byte strobe and byte from the serial receiver
//   i_MemBusy         code memory still initialising; loader waits while high
//   o_RxReady         bytes are accepted (LEN, DATA, CHECK)
//   o_MemWe/o_MemAddr/o_MemData  code memory write port, one pulse per word
//   o_CpuRst          CPU hold-reset, released only on successful load
//   o_CpuEnable       fetch-stage enable, high only after successful load
//   o_Done            load completed and verified
//   o_Error           length overflow or checksum mismatch (held until reset)
module code_mem_loader
  import code_mem_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int BUS_WIDTH = BUS_W
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_RxValid,
  input  logic [7:0]           i_RxData,
  input  logic                 i_MemBusy,
  output logic                 o_RxReady,
  output logic                 o_MemWe,
  output logic [BUS_WIDTH-1:0] o_MemAddr,
  output logic [BUS_WIDTH-1:0] o_MemData,
  output logic                 o_CpuRst,
  output logic                 o_CpuEnable,
  output logic                 o_Done,
  output logic                 o_Error
);

  localparam int IDX_W = BUS_WIDTH - 2;

  loaderState_t         state, nextState;
  logic [IDX_W-1:0]     wordIndex, wordIndexInc;
  logic [BUS_WIDTH-1:0] wordCount;
  logic [7:0]           checksum;
  logic                 rxAccept, packValid, packClear, wordReady;
  logic [31:0]          packWord;

  // Bytes outside LEN/DATA/CHECK (including the WRITE cycle) are dropped.
  assign rxAccept     = i_RxValid && (state == ST_LEN || state == ST_DATA || state == ST_CHECK);
  assign packValid    = i_RxValid && (state == ST_LEN || state == ST_DATA);
  assign packClear    = (state == ST_WAIT_MEM);
  assign wordIndexInc = wordIndex + IDX_W'(1);

  code_mem_loader_byte_packer u_packer (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Clear     (packClear),
    .i_Valid     (packValid),
    .i_Byte      (i_RxData),
    .o_Word      (packWord),
    .o_WordReady (wordReady)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= ST_WAIT_MEM;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_WAIT_MEM: if (!i_MemBusy) nextState = ST_LEN;
      ST_LEN: begin
        if (wordReady) begin
          if (packWord > 32'(MAX_WORDS)) nextState = ST_ERROR;
          else if (packWord == '0)       nextState = ST_CHECK;
          else                           nextState = ST_DATA;
        end
      end
      ST_DATA:  if (wordReady) nextState = ST_WRITE;
      ST_WRITE: begin
        if ({2'b00, wordIndexInc} == wordCount) nextState = ST_CHECK;
        else                                    nextState = ST_DATA;
      end
      ST_CHECK: begin
        if (rxAccept) nextState = (i_RxData == checksum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  nextState = ST_DONE;
      ST_ERROR: nextState = ST_ERROR;
      default:  nextState = ST_WAIT_MEM;
    endcase
  end

  // Word count, write index and running checksum.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || state == ST_WAIT_MEM) begin
      wordCount <= '0;
      wordIndex <= '0;
      checksum  <= '0;
    end else begin
      if (state == ST_LEN && wordReady)  wordCount <= packWord;
      if (state == ST_DATA && rxAccept)  checksum  <= checksum ^ i_RxData;
      if (state == ST_WRITE)             wordIndex <= wordIndexInc;
    end
  end

  // Outputs are registered from the next-state decode so each one is valid
  // in the first cycle of the state it belongs to.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_RxReady   <= 1'b0;
      o_MemWe     <= 1'b0;
      o_MemAddr   <= '0;
      o_MemData   <= '0;
      o_CpuRst    <= 1'b1;
      o_CpuEnable <= 1'b0;
      o_Done      <= 1'b0;
      o_Error     <= 1'b0;
    end else begin
      o_RxReady   <= (nextState == ST_LEN) || (nextState == ST_DATA) || (nextState == ST_CHECK);
      o_MemWe     <= (nextState == ST_WRITE);
      if (nextState == ST_WRITE) begin
        // Word-aligned byte address; consecutive words step by PC_INC.
        o_MemAddr <= {wordIndex, 2'b00};
        o_MemData <= packWord;
      end
      o_CpuRst    <= (nextState != ST_DONE);
      o_CpuEnable <= (nextState == ST_DONE);
      o_Done      <= (nextState == ST_DONE);
      o_Error     <= (nextState == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_code_mem_loader.sv
// tb/tb_code_mem_loader.sv - directed self-checking bench for code_mem_loader
`timescale 1ns/1ps
module tb_code_mem_loader;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_RxValid;
  logic [7:0]  i_RxData;
  logic        i_MemBusy;
  logic        o_RxReady, o_MemWe, o_CpuRst, o_CpuEnable, o_Done, o_Error;
  logic [31:0] o_MemAddr, o_MemData;

  int checks = 0;
  int errors = 0;
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];

  code_mem_loader dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_RxValid   (i_RxValid),
    .i_RxData    (i_RxData),
    .i_MemBusy   (i_MemBusy),
    .o_RxReady   (o_RxReady),
    .o_MemWe     (o_MemWe),
    .o_MemAddr   (o_MemAddr),
    .o_MemData   (o_MemData),
    .o_CpuRst    (o_CpuRst),
    .o_CpuEnable (o_CpuEnable),
    .o_Done      (o_Done),
    .o_Error     (o_Error)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) begin
    if (o_MemWe) begin
      wrAddr.push_back(o_MemAddr);
      wrData.push_back(o_MemData);
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic gap();
    idle(2);
  endtask

  // Presents one byte for one sampling edge; returns 1ns after that edge.
  task automatic sendByte(input logic [7:0] b);
    i_RxValid = 1'b1;
    i_RxData  = b;
    idle(1);
    i_RxValid = 1'b0;
    i_RxData  = 8'h00;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      if (i < 3) gap();
      sendByte(w[i*8 +: 8]);
    end
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [31:0] addr,
                            input logic [31:0] data);
    checkVal({tag, "_addr"}, (wrAddr.size() > idx) ? wrAddr[idx] : 32'hxxxxxxxx, addr);
    checkVal({tag, "_data"}, (wrData.size() > idx) ? wrData[idx] : 32'hxxxxxxxx, data);
  endtask

  task automatic doReset();
    i_Rst     = 1'b1;
    i_RxValid = 1'b0;
    i_RxData  = 8'h00;
    idle(2);
    i_Rst = 1'b0;
    wrAddr.delete();
    wrData.delete();
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Rst = 1'b1; i_RxValid = 1'b0; i_RxData = 8'h00; i_MemBusy = 1'b1;
    idle(2);
    checkVal("rst_rxready", o_RxReady, 0);
    checkVal("rst_memwe", o_MemWe, 0);
    checkVal("rst_addr", o_MemAddr, 0);
    checkVal("rst_data", o_MemData, 0);
    checkVal("rst_cpurst", o_CpuRst, 1);
    checkVal("rst_cpuen", o_CpuEnable, 0);
    checkVal("rst_done", o_Done, 0);
    checkVal("rst_error", o_Error, 0);

    // Test 1: memory busy, stray byte dropped, single word load.
    i_Rst = 1'b0;
    idle(1);
    sendByte(8'hAA);
    checkVal("t1_busy_rxready", o_RxReady, 0);
    idle(3);
    i_MemBusy = 1'b0;
    idle(1);
    checkVal("t1_len_rxready", o_RxReady, 1);
    sendWord(32'h00000001); gap();
    sendWord(32'hDEADBEEF);
    checkVal("t1_we_latency", o_MemWe, 1);
    checkVal("t1_we_addr", o_MemAddr, 32'h0);
    checkVal("t1_we_data", o_MemData, 32'hDEADBEEF);
    checkVal("t1_write_rxready", o_RxReady, 0);
    gap();
    checkVal("t1_cpurst_before", o_CpuRst, 1);
    sendByte(8'h22);
    checkVal("t1_done", o_Done, 1);
    checkVal("t1_cpuen", o_CpuEnable, 1);
    checkVal("t1_cpurst", o_CpuRst, 0);
    checkVal("t1_error", o_Error, 0);
    checkVal("t1_nwrites", wrAddr.size(), 1);

    // Test 2: three words, a byte presented during WRITE is ignored.
    doReset();
    sendWord(32'h00000003); gap();
    sendWord(32'h11111111);
    sendByte(8'h99);
    gap();
    sendWord(32'h22222222); gap();
    sendWord(32'h33333333); gap();
    sendByte(8'h00);
    checkVal("t2_nwrites", wrAddr.size(), 3);
    checkWrite("t2_w0", 0, 32'h0, 32'h11111111);
    checkWrite("t2_w1", 1, 32'h4, 32'h22222222);
    checkWrite("t2_w2", 2, 32'h8, 32'h33333333);
    checkVal("t2_done", o_Done, 1);

    // Test 3: length 1025 exceeds depth.
    doReset();
    sendWord(32'h00000401);
    checkVal("t3_error", o_Error, 1);
    checkVal("t3_cpurst", o_CpuRst, 1);
    checkVal("t3_cpuen", o_CpuEnable, 0);
    checkVal("t3_rxready", o_RxReady, 0);
    gap();
    sendWord(32'hDEADBEEF); gap();
    checkVal("t3_nwrites", wrAddr.size(), 0);
    checkVal("t3_error_sticky", o_Error, 1);
    checkVal("t3_done", o_Done, 0);

    // Test 4: checksum mismatch after a write.
    doReset();
    sendWord(32'h00000001); gap();
    sendWord(32'h01020304); gap();
    checkVal("t4_error_pre", o_Error, 0);
    sendByte(8'h05);
    checkVal("t4_nwrites", wrAddr.size(), 1);
    checkWrite("t4_w0", 0, 32'h0, 32'h01020304);
    checkVal("t4_error", o_Error, 1);
    checkVal("t4_done", o_Done, 0);
    checkVal("t4_cpurst", o_CpuRst, 1);

    // Test 5: empty image.
    doReset();
    sendWord(32'h00000000);
    checkVal("t5_check_rxready", o_RxReady, 1);
    checkVal("t5_no_we", o_MemWe, 0);
    gap();
    sendByte(8'h00);
    checkVal("t5_done", o_Done, 1);
    checkVal("t5_nwrites", wrAddr.size(), 0);

    // Test 6: reset mid-load (with a simultaneous byte), then a full load.
    doReset();
    sendWord(32'h00000001); gap();
    sendByte(8'hAA); gap();
    sendByte(8'hBB); gap();
    checkVal("t6_partial_nwrites", wrAddr.size(), 0);
    i_Rst = 1'b1; i_RxValid = 1'b1; i_RxData = 8'hCC;
    idle(1);
    i_RxValid = 1'b0; i_RxData = 8'h00;
    checkVal("t6_rst_rxready", o_RxReady, 0);
    checkVal("t6_rst_cpurst", o_CpuRst, 1);
    idle(1);
    i_Rst = 1'b0;
    wrAddr.delete();
    wrData.delete();
    idle(1);
    checkVal("t6_len_rxready", o_RxReady, 1);
    sendWord(32'h00000001); gap();
    sendWord(32'hCAFEF00D); gap();
    sendByte(8'hC9);
    checkVal("t6_nwrites", wrAddr.size(), 1);
    checkWrite("t6_w0", 0, 32'h0, 32'hCAFEF00D);
    checkVal("t6_done", o_Done, 1);
    checkVal("t6_cpuen", o_CpuEnable, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_mem_loader.md
# code_mem_loader

Boot-time writer for the VeSPA code memory: receives a byte stream from the SoC serial receiver, assembles 32-bit big-endian instruction words and writes them to the code memory write port at consecutive word addresses. Holds the CPU in reset with fetch disabled until the image is loaded and its checksum verifies. On success it releases the CPU, so the fetch stage starts reading from PC 0.

## Interface
Parameters:
- MAX_WORDS, 1024 — code memory depth in 32-bit words; larger images are rejected.
- BUS_WIDTH, 32 — word and address width; equals the shared bus width constant.

Ports:
- i_Clk  in  1  system clock; all logic updates on its rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_RxValid  in  1  byte strobe from the serial receiver, one cycle per byte.
- i_RxData  in  8  received byte, valid while i_RxValid is high.
- i_MemBusy  in  1  code memory reset-busy flag; the loader does not start until it is low.
- o_RxReady  out  1  high in states that accept bytes (LEN, DATA, CHECK).
- o_MemWe  out  1  code memory write enable, one-cycle pulse per word.
- o_MemAddr  out  BUS_WIDTH  byte address, always word-aligned.
- o_MemData  out  BUS_WIDTH  assembled word.
- o_CpuRst  out  1  CPU hold-reset; high until DONE.
- o_CpuEnable  out  1  drives the fetch-stage enable; high only in DONE.
- o_Done  out  1  load completed and verified.
- o_Error  out  1  sticky; set on length overflow or checksum mismatch.

## Operation
- States: WAIT_MEM, LEN, DATA, WRITE, CHECK, DONE, ERROR.
- WAIT_MEM: leave for LEN on the first cycle with i_MemBusy == 0.
- LEN: accepts 4 bytes, MSB first, into a 32-bit word count N.
  - After the 4th byte: N > MAX_WORDS → ERROR; N == 0 → CHECK; otherwise → DATA.
- DATA: accepts 4 bytes per word. The first byte goes to bits 31:24 and the last to bits 7:0.
  - Each byte is XORed into an 8-bit checksum, which clears in WAIT_MEM.
  - The 4th byte moves the FSM to WRITE.
- WRITE: a single cycle.
  - Drives o_MemWe = 1, o_MemAddr = word_index*4 and o_MemData = assembled word.
  - Then increments word_index and goes to DATA, or to CHECK once word_index+1 == N.
- CHECK: accepts 1 byte. It must equal the running XOR: match → DONE, mismatch → ERROR.
- DONE and ERROR are terminal; only i_Rst leaves them.
- Bytes presented while o_RxReady == 0 (including during WRITE) are discarded and not counted. The upstream sender spaces bytes at least 2 cycles apart, so no data is lost.
- Length bytes are excluded from the checksum.
- Byte-count and word-index arithmetic:
  - byte-in-word counter is 2 bits and wraps 3→0;
  - word_index is BUS_WIDTH-2 bits wide;
  - the address is word_index concatenated with 2'b00.

## Timing
- Reset values: state WAIT_MEM, o_RxReady 0, o_MemWe 0, o_MemAddr 0, o_MemData 0, o_CpuRst 1, o_CpuEnable 0, o_Done 0, o_Error 0, all counters and checksum 0.
- All outputs are registered.
- Write latency: o_MemWe is asserted in the cycle after the cycle in which the 4th data byte is sampled.
- DONE entry: o_CpuRst falls, and o_CpuEnable and o_Done rise, in the cycle after the checksum byte is sampled.
- ERROR entry: o_Error rises in the cycle after the offending byte. o_CpuRst stays 1 and o_CpuEnable stays 0.
- A simultaneous i_RxValid and i_Rst: reset wins and the byte is dropped.
- Reset mid-load: the FSM returns to WAIT_MEM and the CPU is re-held. Memory keeps partial contents, which the next load overwrites.

## Structure
- Shared constants package: BUS width/MSB, PC_INC (4), loader state encodings, MAX_WORDS default.
- One sub-module, byte_packer: a 4-byte shift-in register with a 2-bit counter and a word-ready pulse, used by both LEN and DATA.
- The FSM, address counter and checksum live in code_mem_loader.

## Test plan
- Mem busy held 5 cycles, then bytes 00 00 00 01 DE AD BE EF 22 → no byte accepted while busy; one write at addr 0x0 with data 0xDEADBEEF; o_Done=1, o_CpuEnable=1.
- Three words 0x11111111, 0x22222222, 0x33333333 with correct checksum 0x00 → writes at 0x0, 0x4, 0x8 in order; DONE.
- Length 00 00 04 01 with MAX_WORDS=1024 → ERROR after the 4th length byte; no o_MemWe; o_CpuRst stays 1.
- One word 0x01020304 with checksum byte 0x05 (expected 0x04) → write occurs, then o_Error=1, o_Done=0.
- Length 0 followed by checksum 0x00 → DONE with no writes.
- i_Rst after 6 of 9 bytes, then a full valid stream → the FSM restarts at LEN and the new word is written at addr 0x0.
